// File: rtl/median_filter_engine_pkg.sv
// Shared types and constants for the 3x3 median filter engine.
// Optional build macro: MFE_REPLICATE_BORDER_EN (edge replication instead of zero padding).
package mfe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROWSTART,
    RD,
    CAP,
    MED,
    WR,
    DONE
  } mfe_state_t;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 128;
  localparam int DEF_IMG_H = 128;

  // Address width needed to index every pixel of a w x h image.
  function automatic int mfe_addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/median_filter_engine_if.sv
// Host image/result bus of the median filter engine.
// master = engine side, slave = host side.
interface median_filter_engine_if
  import mfe_pkg::*;
#(
  parameter int ADDR_W = mfe_addr_w(DEF_IMG_W, DEF_IMG_H),
  parameter int PIX_W  = DEF_PIX_W
);

  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic [PIX_W-1:0]  idata;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  data_wr;
  logic              wen;

  modport master (
    input  ready, idata,
    output busy, iaddr, addr, data_wr, wen
  );

  modport slave (
    output ready, idata,
    input  busy, iaddr, addr, data_wr, wen
  );

endinterface

// File: rtl/median_filter_engine_median9.sv
// Combinational median of nine unsigned pixels using the classic
// 19 compare-exchange network; the result is always one of the inputs.
module median9
  import mfe_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic [PIX_W-1:0] pix [9],
  output logic [PIX_W-1:0] med
);

  // Returns {larger, smaller} so callers can write {hi, lo} = cmp_x(lo, hi).
  function automatic logic [2*PIX_W-1:0] cmp_x(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? {a, b} : {b, a};
  endfunction

  // Partial sorting network; only the middle element is guaranteed ordered.
  always_comb begin : sort_net
    logic [PIX_W-1:0] v [9];
    v = pix;
    {v[2], v[1]} = cmp_x(v[1], v[2]);
    {v[5], v[4]} = cmp_x(v[4], v[5]);
    {v[8], v[7]} = cmp_x(v[7], v[8]);
    {v[1], v[0]} = cmp_x(v[0], v[1]);
    {v[4], v[3]} = cmp_x(v[3], v[4]);
    {v[7], v[6]} = cmp_x(v[6], v[7]);
    {v[2], v[1]} = cmp_x(v[1], v[2]);
    {v[5], v[4]} = cmp_x(v[4], v[5]);
    {v[8], v[7]} = cmp_x(v[7], v[8]);
    {v[3], v[0]} = cmp_x(v[0], v[3]);
    {v[8], v[5]} = cmp_x(v[5], v[8]);
    {v[7], v[4]} = cmp_x(v[4], v[7]);
    {v[6], v[3]} = cmp_x(v[3], v[6]);
    {v[4], v[1]} = cmp_x(v[1], v[4]);
    {v[5], v[2]} = cmp_x(v[2], v[5]);
    {v[7], v[4]} = cmp_x(v[4], v[7]);
    {v[2], v[4]} = cmp_x(v[4], v[2]);
    {v[4], v[6]} = cmp_x(v[6], v[4]);
    {v[2], v[4]} = cmp_x(v[4], v[2]);
    med = v[4];
  end

endmodule

// File: rtl/median_filter_engine.sv
// 3x3 median filter engine: streams a W x H image in raster order, keeps a
// sliding 3-column window and writes one median per pixel.
// Optional build macro: MFE_REPLICATE_BORDER_EN selects edge replication
// for the border; without it the border is zero padded.
module median_filter_engine
  import mfe_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = mfe_addr_w(IMG_W, IMG_H)
) (
  input  logic clk,
  input  logic reset,
  median_filter_engine_if.master bus
);

  localparam int X_W  = $clog2(IMG_W + 1);
  localparam int Y_W  = $clog2(IMG_H + 1);
  localparam int LAST = IMG_W * IMG_H - 1;

  mfe_state_t       state;
  logic [X_W-1:0]   x;
  logic [X_W-1:0]   cx;
  logic [Y_W-1:0]   y;
  logic [1:0]       r;
  logic             prefetch;
  logic             pend_zero;
  logic             cap_zero;
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] med_in [9];
  logic [PIX_W-1:0] med;
  logic [PIX_W-1:0] cap_val;

  // Maps a (column, row) fetch to {padding flag, address}; padded fetches
  // read address 0 and their data is replaced by zero at capture.
  function automatic logic [ADDR_W:0] fetch(input int col, input int row);
    int   c;
    int   rr;
    logic oob;
    c   = col;
    rr  = row;
    oob = 1'b0;
`ifdef MFE_REPLICATE_BORDER_EN
    if (rr < 0) rr = 0;
    if (rr >= IMG_H) rr = IMG_H - 1;
    if (c >= IMG_W) c = IMG_W - 1;
`else
    oob = (rr < 0) || (rr >= IMG_H) || (c >= IMG_W);
`endif
    if (oob) return {1'b1, ADDR_W'(0)};
    return {1'b0, ADDR_W'(rr * IMG_W + c)};
  endfunction

  assign cap_val = cap_zero ? '0 : bus.idata;

  // Flatten the window for the median network; ordering does not matter.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        med_in[i*3+j] = win[i][j];
      end
    end
  end

  median9 #(.PIX_W(PIX_W)) u_median9 (
    .pix (med_in),
    .med (med)
  );

  // Control FSM, address generation, window shifting and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x           <= '0;
      cx          <= '0;
      y           <= '0;
      r           <= '0;
      prefetch    <= 1'b0;
      pend_zero   <= 1'b0;
      cap_zero    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.wen     <= 1'b0;
      bus.iaddr   <= '0;
      bus.addr    <= '0;
      bus.data_wr <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      cap_zero <= pend_zero;
      case (state)
        IDLE: begin
          if (bus.ready) begin
            bus.busy <= 1'b1;
            x        <= '0;
            y        <= '0;
            state    <= ROWSTART;
          end
        end
        ROWSTART: begin
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              win[i][j] <= '0;
            end
          end
          cx                   <= '0;
          prefetch             <= 1'b1;
          r                    <= '0;
          {pend_zero, bus.iaddr} <= fetch(0, int'(y) - 1);
          state                <= RD;
        end
        RD: begin
          if (r == 2'd0) begin
            win[0] <= win[1];
            win[1] <= win[2];
          end else begin
            win[2][r - 2'd1] <= cap_val;
          end
          if (r == 2'd2) begin
            state <= CAP;
          end else begin
            r                    <= r + 2'd1;
            {pend_zero, bus.iaddr} <= fetch(int'(cx), int'(y) + int'(r));
          end
        end
        CAP: begin
          win[2][2] <= cap_val;
          if (prefetch) begin
            prefetch             <= 1'b0;
            cx                   <= X_W'(1);
            r                    <= '0;
            {pend_zero, bus.iaddr} <= fetch(1, int'(y) - 1);
            state                <= RD;
`ifdef MFE_REPLICATE_BORDER_EN
            win[1][0] <= win[2][0];
            win[1][1] <= win[2][1];
            win[1][2] <= cap_val;
`endif
          end else begin
            state <= MED;
          end
        end
        MED: begin
          bus.data_wr <= med;
          bus.addr    <= ADDR_W'(int'(y) * IMG_W + int'(x));
          bus.wen     <= 1'b1;
          state       <= WR;
        end
        WR: begin
          bus.wen <= 1'b0;
          if (bus.addr == ADDR_W'(LAST)) begin
            state <= DONE;
          end else if (x == X_W'(IMG_W - 1)) begin
            x     <= '0;
            y     <= y + Y_W'(1);
            state <= ROWSTART;
          end else begin
            x                    <= x + X_W'(1);
            cx                   <= x + X_W'(2);
            r                    <= '0;
            {pend_zero, bus.iaddr} <= fetch(int'(x) + 2, int'(y) - 1);
            state                <= RD;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
